// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative 32x32 multiply / divide unit with HI/LO registers.
module muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        dz,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [4:0] cnt;
  logic [1:0] op_r;
  logic [31:0] a_r, b_r, ma, mb, abs_a, abs_b, q_f, r_f;
  logic [63:0] acc, prod_f;
  logic [32:0] rem, mul_sum, r_sh, diff;
  logic sp, sr, dz_r, accept, div_zero, sgn, is_div;
  assign accept = start && (state == IDLE || state == DONE);
  assign div_zero = op[1] && b == 32'd0;
  assign sgn = ~op_r[0];
  assign is_div = op_r[1];
  assign abs_a = (sgn && a_r[31]) ? -a_r : a_r;
  assign abs_b = (sgn && b_r[31]) ? -b_r : b_r;
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, ma} : 33'd0);
  assign r_sh = {rem[31:0], acc[31]};
  assign diff = r_sh - {1'b0, mb};
  assign prod_f = sp ? -acc : acc;
  assign q_f = sp ? -acc[31:0] : acc[31:0];
  assign r_f = sr ? -rem[31:0] : rem[31:0];
  assign busy = state == PREP || state == RUN || state == FIX;
  assign done = state == DONE;
  assign dz = done && dz_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = accept ? (div_zero ? DONE : PREP) : IDLE;
      PREP:       state_nx = RUN;
      RUN:        state_nx = (cnt == 5'd31) ? FIX : RUN;
      FIX:        state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      ma <= '0;
      mb <= '0;
      acc <= '0;
      rem <= '0;
      sp <= 1'b0;
      sr <= 1'b0;
      dz_r <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      if (accept) begin
        op_r <= op;
        a_r <= a;
        b_r <= b;
        dz_r <= div_zero;
      end
      if (state == PREP) begin
        cnt <= '0;
        ma <= abs_a;
        mb <= abs_b;
        acc <= {32'd0, is_div ? abs_a : abs_b};
        rem <= '0;
        sp <= sgn && (a_r[31] ^ b_r[31]);
        sr <= sgn && a_r[31];
      end
      if (state == RUN) begin
        cnt <= cnt + 5'd1;
        // restoring step: keep the subtraction only when it did not borrow
        if (is_div) begin
          rem <= diff[32] ? r_sh : diff;
          acc[31:0] <= {acc[30:0], ~diff[32]};
        end else acc <= {mul_sum, acc[31:1]};
      end
      if (state == FIX) begin
        hi <= is_div ? r_f : prod_f[63:32];
        lo <= is_div ? q_f : prod_f[31:0];
      end else if ((state == IDLE || state == DONE) && !start) begin
        if (wr_hi) hi <= wdata;
        if (wr_lo) lo <= wdata;
      end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed checks of muldiv_seq results, timing, HI/LO writes and reset.
module tb_muldiv_seq;
  logic clk = 0, rst_n = 0, start = 0, wr_hi = 0, wr_lo = 0;
  logic [1:0] op = 0;
  logic [31:0] a = 0, b = 0, wdata = 0, hi, lo;
  logic busy, done, dz;
  int nvec = 0, nerr = 0;

  muldiv_seq dut (.clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .busy(busy), .done(done), .dz(dz),
    .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  // Issues one start and measures busy cycles and the cycle index of done (-1 if none).
  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     output int nb, output int dn);
    op = o; a = x; b = y; start = 1;
    @(negedge clk);
    start = 0; nb = 0; dn = -1;
    for (int k = 1; k <= 60 && dn < 0; k++) begin
      if (k > 1) @(negedge clk);
      if (busy) nb++;
      if (done) dn = k;
    end
  endtask

  task automatic test_reset;
    nvec++;
    if ({busy, done, dz} !== 3'b000) begin
      nerr++; $display("FAIL reset_flags got %b exp 000", {busy, done, dz});
    end
    nvec++;
    if ({hi, lo} !== 64'd0) begin
      nerr++; $display("FAIL reset_hilo got %h exp 0", {hi, lo});
    end
  endtask

  task automatic test_arith;
    logic [1:0] ops [7] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd0, 2'd2};
    logic [31:0] as [7] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'h80000000, 32'd7};
    logic [31:0] bs [7] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFE};
    logic [31:0] eh [7] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd0, 32'h40000000, 32'd1};
    logic [31:0] el [7] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'd14, 32'h80000000, 32'd0, 32'hFFFFFFFD};
    int nb, dn;
    for (int i = 0; i < 7; i++) begin
      run(ops[i], as[i], bs[i], nb, dn);
      nvec++;
      if (nb !== 34 || dn !== 35) begin
        nerr++; $display("FAIL arith%0d_timing got busy=%0d done_at=%0d exp 34/35", i, nb, dn);
      end
      nvec++;
      if (hi !== eh[i] || lo !== el[i] || dz !== 1'b0) begin
        nerr++; $display("FAIL arith%0d_result got hi=%h lo=%h dz=%b exp hi=%h lo=%h dz=0", i, hi, lo, dz, eh[i], el[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hilo_write;
    int nb, dn;
    logic [31:0] lo_prev;
    wr_hi = 1; wr_lo = 1; wdata = 32'hA5A5A5A5;
    @(negedge clk);
    wr_hi = 0; wr_lo = 0;
    nvec++;
    if (hi !== 32'hA5A5A5A5 || lo !== 32'hA5A5A5A5) begin
      nerr++; $display("FAIL wr_both got hi=%h lo=%h exp a5a5a5a5", hi, lo);
    end
    wr_hi = 1; wdata = 32'h1234;
    @(negedge clk);
    wr_hi = 0;
    nvec++;
    if (hi !== 32'h1234 || lo !== 32'hA5A5A5A5) begin
      nerr++; $display("FAIL wr_hi got hi=%h lo=%h exp 1234/a5a5a5a5", hi, lo);
    end
    lo_prev = lo;
    run(2'd3, 32'd100, 32'd0, nb, dn);
    nvec++;
    if (nb !== 0 || dn !== 1 || dz !== 1'b1) begin
      nerr++; $display("FAIL divzero_timing got busy=%0d done_at=%0d dz=%b exp 0/1/1", nb, dn, dz);
    end
    nvec++;
    if (hi !== 32'h1234 || lo !== lo_prev) begin
      nerr++; $display("FAIL divzero_hilo got hi=%h lo=%h exp 1234/%h", hi, lo, lo_prev);
    end
    @(negedge clk);
    nvec++;
    if ({busy, done, dz} !== 3'b000) begin
      nerr++; $display("FAIL divzero_after got %b exp 000", {busy, done, dz});
    end
    op = 2'd1; a = 32'd2; b = 32'd3; start = 1; wr_hi = 1; wdata = 32'hFFFF;
    @(negedge clk);
    start = 0; wr_hi = 0;
    nvec++;
    if (hi !== 32'h1234 || busy !== 1'b1) begin
      nerr++; $display("FAIL wr_with_start got hi=%h busy=%b exp 1234/1", hi, busy);
    end
    repeat (34) @(negedge clk);
    nvec++;
    if (done !== 1'b1 || hi !== 32'd0 || lo !== 32'd6) begin
      nerr++; $display("FAIL wr_with_start_result got done=%b hi=%h lo=%h exp 1/0/6", done, hi, lo);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_and_reset;
    int dn, nd, nb;
    op = 2'd1; a = 32'd6; b = 32'd7; start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    start = 1; op = 2'd2; a = 32'd9; b = 32'd3; wr_lo = 1; wdata = 32'hDEAD;
    @(negedge clk);
    start = 0; wr_lo = 0;
    dn = -1;
    for (int k = 6; k <= 60 && dn < 0; k++) begin
      if (k > 6) @(negedge clk);
      if (done) dn = k;
    end
    nvec++;
    if (dn !== 35 || hi !== 32'd0 || lo !== 32'd42) begin
      nerr++; $display("FAIL ignore_busy got done_at=%0d hi=%h lo=%h exp 35/0/2a", dn, hi, lo);
    end
    @(negedge clk);
    op = 2'd1; a = 32'd5; b = 32'd5; start = 1;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    rst_n = 0;
    #1;
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      nerr++; $display("FAIL async_reset got busy=%b done=%b hi=%h lo=%h exp 0/0/0/0", busy, done, hi, lo);
    end
    @(negedge clk);
    rst_n = 1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    nvec++;
    if (nd !== 0 || lo !== 32'd0) begin
      nerr++; $display("FAIL abandoned_op got active_cycles=%0d lo=%h exp 0/0", nd, lo);
    end
    run(2'd1, 32'h10000, 32'h10000, nb, dn);
    nvec++;
    if (nb !== 34 || dn !== 35 || hi !== 32'd1 || lo !== 32'd0) begin
      nerr++; $display("FAIL post_reset got busy=%0d done_at=%0d hi=%h lo=%h exp 34/35/1/0", nb, dn, hi, lo);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int nb, dn;
    run(2'd0, 32'd5, 32'hFFFFFFFC, nb, dn);
    nvec++;
    if (dn !== 35 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEC) begin
      nerr++; $display("FAIL b2b_first got done_at=%0d hi=%h lo=%h exp 35/ffffffff/ffffffec", dn, hi, lo);
    end
    run(2'd1, 32'd3, 32'd4, nb, dn);
    nvec++;
    if (nb !== 34 || dn !== 35 || hi !== 32'd0 || lo !== 32'd12) begin
      nerr++; $display("FAIL b2b_second got busy=%0d done_at=%0d hi=%h lo=%h exp 34/35/0/c", nb, dn, hi, lo);
    end
    @(negedge clk);
    nvec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      nerr++; $display("FAIL b2b_idle got done=%b busy=%b exp 0/0", done, busy);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1;
    @(negedge clk);
    test_arith;
    test_hilo_write;
    test_ignore_and_reset;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  32  multiplicand or dividend.
- b  in  32  multiplier or divisor.
- wr_hi  in  1  write wdata into HI (MTHI).
- wr_lo  in  1  write wdata into LO (MTLO).
- wdata  in  32  HI/LO write data.
- busy  out  1  operation in progress; the main controller stalls while it is high.
- done  out  1  one-cycle completion pulse.
- dz  out  1  divide-by-zero flag, pulsed with done.
- hi  out  32  HI register (MFHI source).
- lo  out  32  LO register (MFLO source).

Function
REQ-002 The FSM SHALL have the states IDLE, PREP, RUN, FIX and DONE, plus a 5-bit iteration counter.
REQ-003 op, a and b SHALL be captured only on a rising edge where start=1 and the state is IDLE or DONE.
REQ-004 Normal transitions SHALL be: start accepted -> PREP; PREP -> RUN with counter=0; RUN stays for 32 edges (counter 0..31), then -> FIX; FIX -> DONE; DONE -> IDLE unless a new start is accepted.
REQ-005 If op is DIV or DIVU and b=0 when start is accepted, the next state SHALL be DONE directly, with hi and lo unchanged and dz=1 during that DONE cycle.
REQ-006 PREP SHALL latch operand magnitudes for MULT and DIV (two's-complement absolute value, with 0x80000000 kept as unsigned 2^31) and the raw operands for MULTU and DIVU.
REQ-007 PREP SHALL also record the result signs:
- product sign = a[31] XOR b[31];
- quotient sign = a[31] XOR b[31];
- remainder sign = a[31].
REQ-008 RUN SHALL perform one iteration per cycle:
- multiply: shift-add, 64-bit accumulator;
- divide: restoring shift-subtract, 33-bit partial remainder.
REQ-009 FIX SHALL negate each result whose recorded sign is 1 (signed ops only), then write the results at the FIX -> DONE edge:
- multiply: hi = product[63:32], lo = product[31:0];
- divide: lo = quotient, hi = remainder.
REQ-010 Signed division SHALL truncate toward zero; 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-011 busy SHALL be 1 exactly in PREP, RUN and FIX, and 0 in IDLE and DONE.
REQ-012 done SHALL be 1 exactly in DONE; dz SHALL be 0 outside DONE.
REQ-013 Latency: with start accepted at edge E, busy SHALL be 1 in the 34 cycles after E, and done SHALL be 1 with valid hi/lo in the 35th cycle after E.
REQ-014 A start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-015 wr_hi and wr_lo SHALL update hi and lo at the edge only in IDLE or DONE with start=0; they SHALL be ignored while busy=1 or when start is accepted in the same cycle.
REQ-016 wr_hi and wr_lo asserted together SHALL write both registers with wdata.
REQ-017 hi and lo SHALL hold their values between updates; intermediate iteration values SHALL never appear on hi or lo.
REQ-018 A start accepted in DONE SHALL behave exactly as one accepted in IDLE; done and dz for the previous operation still pulse for that one cycle.
REQ-019 An op or b value that changes after start is accepted SHALL NOT affect the result.

Reset
REQ-020 While rst_n=0, independent of clk, the block SHALL force: state IDLE, counter 0, busy=0, done=0, dz=0, hi=0, lo=0.
REQ-021 A reset during PREP, RUN or FIX SHALL abandon the operation with no hi/lo write.
REQ-022 After rst_n rises, the first accepted start SHALL run the full REQ-013 latency.

Verification
REQ-023 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy for 34 cycles; done in the 35th cycle; hi=0xFFFFFFFE, lo=0x00000001.
REQ-024 MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
REQ-025 DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 100/7 -> lo=14, hi=2.
REQ-026 Preload hi=0x1234 with wr_hi in IDLE, then DIVU a=100 b=0 -> done=1 and dz=1 in the cycle after the start edge; busy never 1; hi=0x1234 unchanged.
REQ-027 During a MULTU in RUN, pulse start with op=DIV and pulse wr_lo=1 -> both ignored, and the original product is written. Then start another op and drive rst_n=0 mid-RUN -> busy=0 and hi=lo=0 immediately, with no later done.
REQ-028 Start in the DONE cycle of a MULT -> done=0 next cycle, busy=1, and the second result arrives 35 cycles after its start edge.
